// File: rtl/tb4004_pkg.sv
// Shared definitions for the register-file access sequencer: opcodes and FSM state encoding.
package tb4004_pkg;

  localparam logic [2:0] OP_LD  = 3'd0;
  localparam logic [2:0] OP_XCH = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_ISZ = 3'd3;
  localparam logic [2:0] OP_FIM = 3'd4;
  localparam logic [2:0] OP_SRC = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reg_alu4.sv
// Combinational result logic for single-register ops: write data, accumulator, carry and skip.
module reg_alu4
  import tb4004_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] r_i,
  input  logic [3:0] acc_i,
  input  logic       carry_i,
  output logic       reg_we_o,
  output logic [3:0] reg_din_o,
  output logic [3:0] acc_o,
  output logic       carry_o,
  output logic       skip_o
);

  logic [3:0] r_inc;
  logic [4:0] add_sum;
  logic [4:0] sub_sum;

  assign r_inc   = r_i + 4'd1;
  assign add_sum = {1'b0, acc_i} + {1'b0, r_i} + {4'd0, carry_i};
  // Subtract as add of complements; carry out of 1 means no borrow.
  assign sub_sum = {1'b0, acc_i} + {1'b0, ~r_i} + {4'd0, ~carry_i};

  always_comb begin
    reg_we_o  = 1'b0;
    reg_din_o = 4'd0;
    acc_o     = acc_i;
    carry_o   = carry_i;
    skip_o    = 1'b0;
    unique case (op_i)
      OP_LD:  acc_o = r_i;
      OP_XCH: begin
        reg_we_o  = 1'b1;
        reg_din_o = acc_i;
        acc_o     = r_i;
      end
      OP_INC: begin
        reg_we_o  = 1'b1;
        reg_din_o = r_inc;
      end
      OP_ISZ: begin
        reg_we_o  = 1'b1;
        reg_din_o = r_inc;
        skip_o    = (r_inc != 4'd0);
      end
      OP_ADD: {carry_o, acc_o} = add_sum;
      OP_SUB: {carry_o, acc_o} = sub_sum;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_access_seq.sv
// Fixed-latency sequencer driving the 16x4 register file for register-operand instructions.
module reg_access_seq
  import tb4004_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [2:0] cmdOp,
  input  logic [3:0] cmdIdx,
  input  logic [3:0] cmdAcc,
  input  logic       cmdCarry,
  input  logic [7:0] cmdImm,
  output logic       regWe,
  output logic [3:0] regAddr,
  output logic [3:0] regDin,
  output logic       pairWe,
  output logic [3:0] pairAddr,
  output logic [7:0] pairDin,
  input  logic [3:0] regDout,
  input  logic [7:0] pairDout,
  output logic       rspValid,
  input  logic       rspReady,
  output logic [3:0] rspAcc,
  output logic       rspCarry,
  output logic [7:0] rspPair,
  output logic       rspSkip
);

  seq_state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic [7:0] imm_q, imm_d;
  logic       reg_we_q, reg_we_d;
  logic       pair_we_q, pair_we_d;
  logic [3:0] reg_addr_q, reg_addr_d;
  logic [3:0] pair_addr_q, pair_addr_d;
  logic [3:0] reg_din_q, reg_din_d;
  logic [7:0] pair_din_q, pair_din_d;
  logic [3:0] rsp_acc_q, rsp_acc_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic [7:0] rsp_pair_q, rsp_pair_d;
  logic       rsp_skip_q, rsp_skip_d;

  logic       alu_reg_we;
  logic [3:0] alu_reg_din;
  logic [3:0] alu_acc;
  logic       alu_carry;
  logic       alu_skip;

  // Fed straight from the file's read port so the strobe can be registered for the WRITE cycle.
  reg_alu4 u_alu (
    .op_i      (op_q),
    .r_i       (regDout),
    .acc_i     (acc_q),
    .carry_i   (carry_q),
    .reg_we_o  (alu_reg_we),
    .reg_din_o (alu_reg_din),
    .acc_o     (alu_acc),
    .carry_o   (alu_carry),
    .skip_o    (alu_skip)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    imm_d       = imm_q;
    reg_we_d    = 1'b0;
    pair_we_d   = 1'b0;
    reg_addr_d  = reg_addr_q;
    pair_addr_d = pair_addr_q;
    reg_din_d   = reg_din_q;
    pair_din_d  = pair_din_q;
    rsp_acc_d   = rsp_acc_q;
    rsp_carry_d = rsp_carry_q;
    rsp_pair_d  = rsp_pair_q;
    rsp_skip_d  = rsp_skip_q;
    unique case (state_q)
      StIdle: begin
        if (cmdValid) begin
          op_d        = cmdOp;
          acc_d       = cmdAcc;
          carry_d     = cmdCarry;
          imm_d       = cmdImm;
          reg_addr_d  = cmdIdx;
          pair_addr_d = {cmdIdx[3:1], 1'b0};
          state_d     = StRead;
        end
      end
      StRead: begin
        reg_we_d    = alu_reg_we;
        pair_we_d   = (op_q == OP_FIM);
        if (alu_reg_we) reg_din_d = alu_reg_din;
        if (op_q == OP_FIM) pair_din_d = imm_q;
        rsp_acc_d   = alu_acc;
        rsp_carry_d = alu_carry;
        rsp_skip_d  = alu_skip;
        rsp_pair_d  = (op_q == OP_FIM) ? imm_q :
                      (op_q == OP_SRC) ? pairDout : 8'd0;
        state_d     = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  if (rspReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      op_q        <= OP_LD;
      acc_q       <= 4'd0;
      carry_q     <= 1'b0;
      imm_q       <= 8'd0;
      reg_we_q    <= 1'b0;
      pair_we_q   <= 1'b0;
      reg_addr_q  <= 4'd0;
      pair_addr_q <= 4'd0;
      reg_din_q   <= 4'd0;
      pair_din_q  <= 8'd0;
      rsp_acc_q   <= 4'd0;
      rsp_carry_q <= 1'b0;
      rsp_pair_q  <= 8'd0;
      rsp_skip_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      imm_q       <= imm_d;
      reg_we_q    <= reg_we_d;
      pair_we_q   <= pair_we_d;
      reg_addr_q  <= reg_addr_d;
      pair_addr_q <= pair_addr_d;
      reg_din_q   <= reg_din_d;
      pair_din_q  <= pair_din_d;
      rsp_acc_q   <= rsp_acc_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_pair_q  <= rsp_pair_d;
      rsp_skip_q  <= rsp_skip_d;
    end
  end

  assign cmdReady = (state_q == StIdle);
  assign rspValid = (state_q == StResp);
  assign regWe    = reg_we_q;
  assign pairWe   = pair_we_q;
  assign regAddr  = reg_addr_q;
  assign pairAddr = pair_addr_q;
  assign regDin   = reg_din_q;
  assign pairDin  = pair_din_q;
  assign rspAcc   = rsp_acc_q;
  assign rspCarry = rsp_carry_q;
  assign rspPair  = rsp_pair_q;
  assign rspSkip  = rsp_skip_q;

endmodule
